// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative FFT engine:
// complex struct, FSM state enum, bit-reverse and twiddle constant functions.
package fft_pkg;

  localparam int  CPLX_W = 64;
  localparam real PI     = 3.14159265358979323846;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } fft_state_t;

  function automatic int bit_reverse(input int index, input int l);
    int r;
    r = 0;
    for (int b = 0; b < l; b++) begin
      r = r | (((index >> b) & 1) << (l - 1 - b));
    end
    return r;
  endfunction

  // W_n^k = exp(-j*2*pi*k/n) in Q(bit_width-decimal_pt).decimal_pt, rounded to nearest.
  function automatic cplx_t twiddle(input int k, input int n, input int bit_width,
                                    input int decimal_pt);
    real    ang;
    real    scale;
    longint c;
    longint s;
    cplx_t  w;
    ang   = 2.0 * PI * real'(k) / real'(n);
    scale = real'(longint'(1) <<< decimal_pt);
    c     = longint'($floor($cos(ang) * scale + 0.5));
    s     = -longint'($floor($sin(ang) * scale + 0.5));
    c     = (c <<< (64 - bit_width)) >>> (64 - bit_width);
    s     = (s <<< (64 - bit_width)) >>> (64 - bit_width);
    w.re  = c;
    w.im  = s;
    return w;
  endfunction

endpackage

// File: rtl/fft_iterative_if.sv
// Frame handshake bundle for fft_iterative; the inverse control exists only
// when FFT_INVERSE_EN is defined.
interface fft_iterative_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  // A frame moves on a rising clk edge where val && rdy are both high. The
  // sender holds val and data stable until that edge; the engine holds
  // send_val and send_real/send_imag stable until send_rdy is seen.
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_real;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_imag;
  logic                                recv_val;
  logic                                recv_rdy;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_real;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_imag;
  logic                                send_val;
  logic                                send_rdy;
`ifdef FFT_INVERSE_EN
  logic                                inverse;

  modport master (output recv_real, recv_imag, recv_val, inverse, send_rdy,
                  input  recv_rdy, send_real, send_imag, send_val);
  modport slave  (input  recv_real, recv_imag, recv_val, inverse, send_rdy,
                  output recv_rdy, send_real, send_imag, send_val);
`else
  modport master (output recv_real, recv_imag, recv_val, send_rdy,
                  input  recv_rdy, send_real, send_imag, send_val);
  modport slave  (input  recv_real, recv_imag, recv_val, send_rdy,
                  output recv_rdy, send_real, send_imag, send_val);
`endif
endinterface

// File: rtl/fft_butterfly_comb.sv
// Purely combinational radix-2 butterfly c = a + w*b, d = a - w*b with an
// optional conjugated twiddle and a halving of both outputs.
module fft_butterfly_comb #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16
) (
  input  logic signed [BIT_WIDTH-1:0] a_re,
  input  logic signed [BIT_WIDTH-1:0] a_im,
  input  logic signed [BIT_WIDTH-1:0] b_re,
  input  logic signed [BIT_WIDTH-1:0] b_im,
  input  logic signed [BIT_WIDTH-1:0] w_re,
  input  logic signed [BIT_WIDTH-1:0] w_im,
  input  logic                        conj,
  input  logic                        scale,
  output logic signed [BIT_WIDTH-1:0] c_re,
  output logic signed [BIT_WIDTH-1:0] c_im,
  output logic signed [BIT_WIDTH-1:0] d_re,
  output logic signed [BIT_WIDTH-1:0] d_im
);
  localparam int PW = 2 * BIT_WIDTH;

  logic signed [PW-1:0]        br, bi, wr, wi;
  logic signed [PW-1:0]        prod_re, prod_im;
  logic signed [BIT_WIDTH-1:0] wb_re, wb_im;
  logic signed [BIT_WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;

  always_comb begin
    br      = PW'(b_re);
    bi      = PW'(b_im);
    wr      = PW'(w_re);
    wi      = conj ? -PW'(w_im) : PW'(w_im);
    // Full-width products, then one shift back to the Q format; adds wrap.
    prod_re = br * wr - bi * wi;
    prod_im = br * wi + bi * wr;
    wb_re   = BIT_WIDTH'(prod_re >>> DECIMAL_PT);
    wb_im   = BIT_WIDTH'(prod_im >>> DECIMAL_PT);
    sum_re  = a_re + wb_re;
    sum_im  = a_im + wb_im;
    dif_re  = a_re - wb_re;
    dif_im  = a_im - wb_im;
    c_re    = scale ? (sum_re >>> 1) : sum_re;
    c_im    = scale ? (sum_im >>> 1) : sum_im;
    d_re    = scale ? (dif_re >>> 1) : dif_re;
    d_im    = scale ? (dif_im >>> 1) : dif_im;
  end
endmodule

// File: rtl/fft_iterative.sv
// Resource-shared radix-2 DIT FFT: one stage per cycle through N/2 shared
// butterflies. Define FFT_INVERSE_EN to add the inverse (1/N scaled) transform.
module fft_iterative
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8
) (
  input  logic            clk,
  input  logic            reset,
  fft_iterative_if.slave  bus,
  output fft_state_t      dbg_state
);
  localparam int L    = $clog2(N_SAMPLES);
  localparam int HALF = N_SAMPLES / 2;
  localparam int SW   = $clog2(L + 1);

  fft_state_t    state;
  logic [SW-1:0] stage;
  logic          send_val_q;
  logic          inv_q;
  logic          inv_in;
  logic          rdy;
  logic          accept;

  logic signed [BIT_WIDTH-1:0] work_re [N_SAMPLES];
  logic signed [BIT_WIDTH-1:0] work_im [N_SAMPLES];
  logic signed [BIT_WIDTH-1:0] next_re [N_SAMPLES];
  logic signed [BIT_WIDTH-1:0] next_im [N_SAMPLES];
  logic signed [BIT_WIDTH-1:0] a_re [HALF], a_im [HALF], b_re [HALF], b_im [HALF];
  logic signed [BIT_WIDTH-1:0] w_re [HALF], w_im [HALF];
  logic signed [BIT_WIDTH-1:0] c_re [HALF], c_im [HALF], d_re [HALF], d_im [HALF];
  logic signed [BIT_WIDTH-1:0] tw_re [HALF][L];
  logic signed [BIT_WIDTH-1:0] tw_im [HALF][L];

  // Butterfly j of stage st: upper leg index; the lower leg sits 2^st above it.
  function automatic int top_idx(input int j, input int st);
    return ((j >> st) << (st + 1)) + (j & ((1 << st) - 1));
  endfunction

`ifdef FFT_INVERSE_EN
  assign inv_in = bus.inverse;
`else
  assign inv_in = 1'b0;
`endif

  assign rdy          = !reset && ((state == IDLE) || (state == DONE && bus.send_rdy));
  assign accept       = bus.recv_val && rdy;
  assign bus.recv_rdy = rdy;
  assign bus.send_val = send_val_q;
  assign dbg_state    = state;

  for (genvar j = 0; j < HALF; j++) begin : g_bfly
    for (genvar st = 0; st < L; st++) begin : g_tw
      localparam cplx_t TW = twiddle((j % (1 << st)) * (N_SAMPLES >> (st + 1)),
                                     N_SAMPLES, BIT_WIDTH, DECIMAL_PT);
      assign tw_re[j][st] = BIT_WIDTH'(TW.re);
      assign tw_im[j][st] = BIT_WIDTH'(TW.im);
    end

    fft_butterfly_comb #(.BIT_WIDTH(BIT_WIDTH), .DECIMAL_PT(DECIMAL_PT)) u_bfly (
      .a_re (a_re[j]), .a_im (a_im[j]), .b_re (b_re[j]), .b_im (b_im[j]),
      .w_re (w_re[j]), .w_im (w_im[j]), .conj (inv_q), .scale (inv_q),
      .c_re (c_re[j]), .c_im (c_im[j]), .d_re (d_re[j]), .d_im (d_im[j])
    );
  end

  always_comb begin
    for (int j = 0; j < HALF; j++) begin
      a_re[j] = '0;
      a_im[j] = '0;
      b_re[j] = '0;
      b_im[j] = '0;
      w_re[j] = '0;
      w_im[j] = '0;
      for (int st = 0; st < L; st++) begin
        if (stage == SW'(st)) begin
          a_re[j] = work_re[top_idx(j, st)];
          a_im[j] = work_im[top_idx(j, st)];
          b_re[j] = work_re[top_idx(j, st) + (1 << st)];
          b_im[j] = work_im[top_idx(j, st) + (1 << st)];
          w_re[j] = tw_re[j][st];
          w_im[j] = tw_im[j][st];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SAMPLES; i++) begin
      next_re[i] = work_re[i];
      next_im[i] = work_im[i];
    end
    for (int st = 0; st < L; st++) begin
      if (stage == SW'(st)) begin
        for (int j = 0; j < HALF; j++) begin
          next_re[top_idx(j, st)]              = c_re[j];
          next_im[top_idx(j, st)]              = c_im[j];
          next_re[top_idx(j, st) + (1 << st)]  = d_re[j];
          next_im[top_idx(j, st) + (1 << st)]  = d_im[j];
        end
      end
    end
  end

  // Results are only visible in DONE, so a partially computed frame never leaks.
  always_comb begin
    for (int i = 0; i < N_SAMPLES; i++) begin
      bus.send_real[i] = (state == DONE) ? work_re[i] : '0;
      bus.send_imag[i] = (state == DONE) ? work_im[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stage      <= '0;
      send_val_q <= 1'b0;
      inv_q      <= 1'b0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        work_re[i] <= '0;
        work_im[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        work_re[bit_reverse(i, L)] <= $signed(bus.recv_real[i]);
        work_im[bit_reverse(i, L)] <= $signed(bus.recv_imag[i]);
      end
      inv_q      <= inv_in;
      state      <= COMPUTE;
      stage      <= '0;
      send_val_q <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        COMPUTE: begin
          for (int i = 0; i < N_SAMPLES; i++) begin
            work_re[i] <= next_re[i];
            work_im[i] <= next_im[i];
          end
          if (stage == SW'(L - 1)) begin
            state      <= DONE;
            send_val_q <= 1'b1;
          end else begin
            stage <= stage + 1'b1;
          end
        end
        DONE: begin
          if (bus.send_rdy) begin
            state      <= IDLE;
            send_val_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_iterative.sv
// Self-checking bench for fft_iterative (N=8, Q16.16): directed frames from the
// datasheet plus randomized frames checked against a floating-point DFT model.
module tb_fft_iterative;
  import fft_pkg::*;

  localparam int     BW   = 32;
  localparam int     DP   = 16;
  localparam int     N    = 8;
  localparam int     L    = 3;
  localparam longint ONE  = 64'sd65536;
  localparam longint RTOL = 24;

  logic       clk = 1'b0;
  logic       reset;
  fft_state_t dbg_state;

  fft_iterative_if #(.BIT_WIDTH(BW), .N_SAMPLES(N)) bus ();

  fft_iterative #(.BIT_WIDTH(BW), .DECIMAL_PT(DP), .N_SAMPLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [BW-1:0] exp_q[$];
  longint        in_re [N];
  longint        in_im [N];
  bit            in_inv;

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol);
    longint diff;
    vectors++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: direct DFT (or 1/N-scaled IDFT) in real arithmetic.
  task automatic push_expected();
    real sr, si, ang, sgn;
    sgn = in_inv ? 1.0 : -1.0;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = sgn * 2.0 * PI * real'(k * n) / real'(N);
        sr  = sr + real'(in_re[n]) * $cos(ang) - real'(in_im[n]) * $sin(ang);
        si  = si + real'(in_re[n]) * $sin(ang) + real'(in_im[n]) * $cos(ang);
      end
      if (in_inv) begin
        sr = sr / real'(N);
        si = si / real'(N);
      end
      exp_q.push_back(BW'(longint'($floor(sr + 0.5))));
      exp_q.push_back(BW'(longint'($floor(si + 0.5))));
    end
  endtask

  task automatic check_result(input string tag, input longint tol, input bit pop);
    if (exp_q.size() < 2 * N) begin
      check({tag, "_queue"}, longint'(exp_q.size()), 2 * N, 0);
      return;
    end
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_re%0d", tag, k), longint'($signed(bus.send_real[k])),
            longint'($signed(exp_q[2*k])), tol);
      check($sformatf("%s_im%0d", tag, k), longint'($signed(bus.send_imag[k])),
            longint'($signed(exp_q[2*k+1])), tol);
    end
    if (pop) repeat (2 * N) void'(exp_q.pop_front());
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      in_re[i] = 0;
      in_im[i] = 0;
    end
    in_inv = 1'b0;
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) begin
      in_re[i] = longint'($urandom_range(0, 65536)) - 32768;
      in_im[i] = longint'($urandom_range(0, 65536)) - 32768;
    end
`ifdef FFT_INVERSE_EN
    in_inv = 1'($urandom_range(0, 1));
`else
    in_inv = 1'b0;
`endif
  endtask

  task automatic set_inputs();
    for (int i = 0; i < N; i++) begin
      bus.recv_real[i] = BW'(in_re[i]);
      bus.recv_imag[i] = BW'(in_im[i]);
    end
`ifdef FFT_INVERSE_EN
    bus.inverse = in_inv;
`endif
  endtask

  // Called at the negedge after the accepting edge; presents junk with
  // recv_val high (must be ignored) and counts cycles until send_val.
  task automatic wait_result(output int lat);
    lat = 1;
    for (int i = 0; i < N; i++) begin
      bus.recv_real[i] = BW'($urandom());
      bus.recv_imag[i] = BW'($urandom());
    end
    bus.recv_val = 1'b1;
    while (!bus.send_val && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send_frame(output int lat);
    int waited;
    waited = 0;
    set_inputs();
    bus.recv_val = 1'b1;
    while (!bus.recv_rdy && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", longint'(waited >= 64), 0, 0);
    push_expected();
    @(posedge clk);
    @(negedge clk);
    wait_result(lat);
  endtask

  task automatic consume();
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send_rdy = 1'b0;
    check("consumed_send_val", bus.send_val, 0, 0);
  endtask

  initial begin
    int lat;
    int stale;
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b0;
    clear_frame();
    set_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rdy_in_reset", bus.recv_rdy, 0, 0);
    reset = 1'b0;
    #1;
    check("rst_send_val", bus.send_val, 0, 0);
    check("rst_recv_rdy", bus.recv_rdy, 1, 0);
    check("rst_state", dbg_state, IDLE, 0);
    check("rst_data", longint'((|bus.send_real) | (|bus.send_imag)), 0, 0);

    // Impulse: flat spectrum of 1.0
    clear_frame();
    in_re[0] = ONE;
    send_frame(lat);
    check("impulse_latency", lat, L + 1, 0);
    check("impulse_x5_const", longint'($signed(bus.send_real[5])), ONE, 1);
    check_result("impulse", 1, 1);
    consume();

    // DC: all energy in bin 0
    clear_frame();
    for (int i = 0; i < N; i++) in_re[i] = ONE;
    send_frame(lat);
    check("dc_x0_const", longint'($signed(bus.send_real[0])), 8 * ONE, 1);
    check_result("dc", 1, 1);
    consume();

    // Alternating sign: all energy in bin N/2
    clear_frame();
    for (int i = 0; i < N; i++) in_re[i] = (i % 2 == 1) ? -ONE : ONE;
    send_frame(lat);
    check("alt_x4_const", longint'($signed(bus.send_real[4])), 8 * ONE, 1);
    check_result("alt", 1, 1);
    consume();

    // Backpressure for 5 cycles, then consume and accept on the same edge
    random_frame();
    send_frame(lat);
    check("bp_latency", lat, L + 1, 0);
    random_frame();
    set_inputs();
    bus.recv_val = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_recv_rdy", bus.recv_rdy, 0, 0);
      check("bp_send_val", bus.send_val, 1, 0);
      check_result("bp_stall", RTOL, 0);
      @(negedge clk);
    end
    bus.send_rdy = 1'b1;
    #1;
    check("b2b_recv_rdy", bus.recv_rdy, 1, 0);
    repeat (2 * N) void'(exp_q.pop_front());
    push_expected();
    @(posedge clk);
    @(negedge clk);
    bus.send_rdy = 1'b0;
    check("b2b_send_val_drop", bus.send_val, 0, 0);
    wait_result(lat);
    check("b2b_latency", lat, L + 1, 0);
    check_result("b2b", RTOL, 1);
    consume();

    // Reset while stage 1 is pending: frame discarded, nothing stale shown
    random_frame();
    set_inputs();
    bus.recv_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.recv_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_send_val", bus.send_val, 0, 0);
    check("midrst_recv_rdy", bus.recv_rdy, 1, 0);
    check("midrst_data", longint'((|bus.send_real) | (|bus.send_imag)), 0, 0);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.send_val) stale++;
    end
    check("midrst_no_stale", stale, 0, 0);

`ifdef FFT_INVERSE_EN
    clear_frame();
    in_inv   = 1'b1;
    in_re[0] = 8 * ONE;
    send_frame(lat);
    check("inv_x3_const", longint'($signed(bus.send_real[3])), ONE, 1);
    check_result("inverse", 1, 1);
    consume();
`endif

    // Randomized frames with random consumer stalls
    for (int f = 0; f < 8; f++) begin
      random_frame();
      send_frame(lat);
      check($sformatf("rand%0d_latency", f), lat, L + 1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_result($sformatf("rand%0d", f), RTOL, 1);
      consume();
    end

    check("queue_empty", longint'(exp_q.size()), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
